mem_master: RTL and testbench
=============================

# mem_master

Bus initiator for the 16×8 asynchronous-read, level-write memory: converts valid/ready access requests from the CPU core into safely sequenced address/read/write strobes. Supports single-word writes and 1–16 word incrementing read bursts. Responses are returned on a backpressurable stream. Sits between the CPU control unit and the memory.

## Interface
- ADDR_W, 4, memory address width; burst addresses wrap modulo 2^ADDR_W
- DATA_W, 8, data word width
- WAIT_CYCLES, 0, extra cycles each strobe is held beyond the minimum of one; range 0..7
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present; must stay stable until accepted
- req_ready  out  1  high only in IDLE; accept = req_valid & req_ready at an edge
- req_write  in  1  1 = single-word write, 0 = read burst
- req_addr  in  ADDR_W  start address
- req_len  in  4  read burst length minus one (0..15 = 1..16 beats); ignored for writes
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  read beat available
- rsp_ready  in  1  consumer accepts the beat
- rsp_data  out  DATA_W  read data; stable while rsp_valid is high
- rsp_last  out  1  marks the final beat of a burst
- mem_address  out  ADDR_W  to memory address
- mem_read  out  1  to memory read strobe
- mem_write  out  1  to memory write strobe
- mem_data_in  out  DATA_W  to memory write data
- mem_data_out  in  DATA_W  from memory read data
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, RESP.
- Every mem_* output is driven straight from flops, so strobes are glitch-free.
- **IDLE:** req_ready=1 and strobes are low. On accept, latch the address, length and data, and set the beat counter to 0. Go to SETUP.
- **SETUP:** drive mem_address (and mem_data_in for a write) with both strobes low. Lasts 1 cycle, then STROBE.
- **STROBE:** assert mem_read or mem_write, never both. Lasts WAIT_CYCLES+1 cycles, counted by a wait counter.
  - Read: on the edge that ends the last STROBE cycle, register mem_data_out into rsp_data and go to RESP.
  - Write: go to HOLD.
- **HOLD (write only):** strobe low, address and data unchanged. Lasts 1 cycle, then IDLE. A write produces no response; completion is signalled by req_ready returning high.
- **RESP:** rsp_valid=1, and rsp_last=1 when beat counter == latched len. Strobes are low and mem_address is held.
  - On rsp_valid & rsp_ready: if last, go to IDLE.
  - Otherwise, address = address+1 modulo 2^ADDR_W (15→0), beat counter +1, go to SETUP.
- mem_address and mem_data_in never change while a strobe is high. This is required because the memory write is level-sensitive.
- While busy, req_valid is ignored; there is no queuing.
- The data on rsp_data is whatever the memory returned at the sample edge. No checking is performed.

## Timing
- Reset values:
  - state IDLE, req_ready=1, busy=0
  - rsp_valid=0, rsp_last=0, rsp_data=0
  - mem_read=0, mem_write=0, mem_address=0, mem_data_in=0
- Reset mid-operation: strobes drop asynchronously and the burst is abandoned with no partial response. Operation resumes from IDLE on the first edge after release.
- Cycle numbering below: cycle 0 is the accept edge; cycle 1 starts there. W = WAIT_CYCLES.
- Write:
  - SETUP is cycle 1; mem_write is high for cycles 2..2+W; HOLD is cycle 3+W.
  - req_ready is high again in cycle 4+W.
- Read, per beat:
  - SETUP, then mem_read high for W+1 cycles, then rsp_valid rises in cycle 3+W after the beat started.
  - With rsp_ready tied high, one beat every W+3 cycles.
- Backpressure (rsp_ready low): hold RESP indefinitely. rsp_data and rsp_last stay stable, with no memory activity.

## Test plan
Bench memory model is preloaded with M[9]=08, M[10]=02, M[11]=E0, M[12]=0B. All scenarios use W=0 unless stated.

- **Single read:** read addr 12, len 0 → mem_read high exactly 1 cycle (cycle 2); rsp_valid in cycle 3 with rsp_data=0x0B, rsp_last=1; req_ready high the cycle after the handshake.
- **Burst read:** read addr 9, len 3, rsp_ready=1 → beats 08, 02, E0, 0B, 3 cycles apart; rsp_last only on the 4th beat.
- **Wrap-around:** read addr 14, len 3 → mem_address sequence 14, 15, 0, 1; 4 beats; rsp_last on addr 1.
- **Write then read-back:** write addr 13, data 0xA5 → address and data stable from SETUP through HOLD; mem_write high exactly 1 cycle; no rsp_valid. Then read addr 13 → rsp_data=0xA5.
- **Backpressure and wait states:** with W=2, read addr 9, len 1, rsp_ready low for 5 cycles on beat 1 → mem_read high 3 cycles per beat; rsp_data=08 held, no strobe during the stall; then beat 02 with rsp_last=1.
- **Reset mid-burst and request while busy:** rst_n low during STROBE of beat 2 of a len-3 read → mem_read=0 and rsp_valid=0 immediately; after release req_ready=1 and no memory activity. A req_valid pulse during a busy burst is not accepted.

Source files
------------

// File: rtl/mem_master_if.sv
// Request, response and memory-side signals of the mem_master bus initiator.
// The master modport is the initiator's view; slave is the view of the CPU and memory side.
interface mem_master_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_len;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    modport master (
        input  req_valid, req_write, req_addr, req_len, req_wdata, rsp_ready, mem_data_out,
        output req_ready, rsp_valid, rsp_data, rsp_last, mem_address, mem_read, mem_write,
               mem_data_in
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len, req_wdata, rsp_ready, mem_data_out,
        input  req_ready, rsp_valid, rsp_data, rsp_last, mem_address, mem_read, mem_write,
               mem_data_in
    );
endinterface

// File: rtl/mem_master.sv
// Bus initiator for an asynchronous-read, level-write memory: single-word writes and
// incrementing read bursts, with every memory-side output driven straight from a flop.
module mem_master #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_master_if.master     bus,
    output logic             busy
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [3:0]        len_q, len_d;
    logic [3:0]        beat_q, beat_d;
    logic [2:0]        wait_q, wait_d;
    logic              write_q, write_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              last_beat;

    assign last_beat = (beat_q == len_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        len_d   = len_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        write_d = write_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    len_d   = bus.req_len;
                    wdata_d = bus.req_wdata;
                    write_d = bus.req_write;
                    beat_d  = 4'd0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                // Strobe flops are loaded here so the strobe rises one cycle after the address settles
                wait_d  = 3'd0;
                rd_d    = !write_q;
                wr_d    = write_q;
                state_d = STROBE;
            end
            STROBE: begin
                if (wait_q == WAIT_LAST) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (write_q) begin
                        state_d = HOLD;
                    end else begin
                        rdata_d = bus.mem_data_out;
                        state_d = RESP;
                    end
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        beat_d  = beat_q + 4'd1;
                        state_d = SETUP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            wait_q  <= '0;
            write_q <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            write_q <= write_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign busy            = (state_q != IDLE);
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_last    = (state_q == RESP) && last_beat;
    assign bus.rsp_data    = rdata_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_data_in = wdata_q;
    assign bus.mem_read    = rd_q;
    assign bus.mem_write   = wr_q;
endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master: two instances (no wait states and two wait states),
// each driving a behavioural 16x8 memory, with a response scoreboard per instance.
module tb_mem_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_master_if #(.ADDR_W(4), .DATA_W(8)) bus0 ();
    mem_master_if #(.ADDR_W(4), .DATA_W(8)) bus1 ();
    logic busy0, busy1;

    mem_master #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.master), .busy(busy0));
    mem_master #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.master), .busy(busy1));

    logic [7:0] mem0 [16];
    logic [7:0] mem1 [16];
    assign bus0.mem_data_out = mem0[bus0.mem_address];
    assign bus1.mem_data_out = mem1[bus1.mem_address];
    always @(posedge clk) if (bus0.mem_write) mem0[bus0.mem_address] <= bus0.mem_data_in;
    always @(posedge clk) if (bus1.mem_write) mem1[bus1.mem_address] <= bus1.mem_data_in;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0] exp0 [$];
    logic [8:0] exp1 [$];
    int         stamp0 [$];
    logic [3:0] raddr0 [$];
    int rd_cnt0 = 0, wr_cnt0 = 0, rd_cnt1 = 0;
    logic       prev_stb0 = 1'b0, prev_stb1 = 1'b0;
    logic [3:0] prev_a0 = '0, prev_a1 = '0;
    logic [7:0] prev_d0 = '0, prev_d1 = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitors sample on the falling edge, half a cycle away from the DUT's active edge.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n) begin
            if (bus0.mem_read) rd_cnt0++;
            if (bus0.mem_write) wr_cnt0++;
            if (bus0.mem_read && !prev_stb0) raddr0.push_back(bus0.mem_address);
            if (bus0.mem_read || bus0.mem_write) begin
                check("one_strobe0", 32'(bus0.mem_read & bus0.mem_write), 0);
                if (prev_stb0) begin
                    check("addr_stable0", 32'(bus0.mem_address), 32'(prev_a0));
                    check("wdata_stable0", 32'(bus0.mem_data_in), 32'(prev_d0));
                end
            end
            prev_stb0 = bus0.mem_read | bus0.mem_write;
            prev_a0   = bus0.mem_address;
            prev_d0   = bus0.mem_data_in;
            if (bus0.rsp_valid && bus0.rsp_ready) begin
                check("sb_pending0", 32'(exp0.size() != 0), 1);
                if (exp0.size() != 0) begin
                    e = exp0.pop_front();
                    check("rsp_data0", 32'(bus0.rsp_data), 32'(e[7:0]));
                    check("rsp_last0", 32'(bus0.rsp_last), 32'(e[8]));
                    stamp0.push_back(cyc);
                end
            end
        end else begin
            prev_stb0 = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n) begin
            if (bus1.mem_read) rd_cnt1++;
            if (bus1.mem_read || bus1.mem_write) begin
                check("one_strobe1", 32'(bus1.mem_read & bus1.mem_write), 0);
                if (prev_stb1) begin
                    check("addr_stable1", 32'(bus1.mem_address), 32'(prev_a1));
                    check("wdata_stable1", 32'(bus1.mem_data_in), 32'(prev_d1));
                end
            end
            prev_stb1 = bus1.mem_read | bus1.mem_write;
            prev_a1   = bus1.mem_address;
            prev_d1   = bus1.mem_data_in;
            if (bus1.rsp_valid && bus1.rsp_ready) begin
                check("sb_pending1", 32'(exp1.size() != 0), 1);
                if (exp1.size() != 0) begin
                    e = exp1.pop_front();
                    check("rsp_data1", 32'(bus1.rsp_data), 32'(e[7:0]));
                    check("rsp_last1", 32'(bus1.rsp_last), 32'(e[8]));
                end
            end
        end else begin
            prev_stb1 = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one time unit after an edge with the target idle; returns in cycle 1.
    task automatic send(input int u, input logic w, input logic [3:0] a,
                        input logic [3:0] l, input logic [7:0] d);
        if (u == 0) begin
            bus0.req_valid = 1'b1; bus0.req_write = w; bus0.req_addr = a;
            bus0.req_len = l; bus0.req_wdata = d;
        end else begin
            bus1.req_valid = 1'b1; bus1.req_write = w; bus1.req_addr = a;
            bus1.req_len = l; bus1.req_wdata = d;
        end
        tick();
        bus0.req_valid = 1'b0;
        bus1.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int u, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!(u == 0 ? busy0 : busy1)) break;
            tick();
        end
        check("idle_timeout", 32'(u == 0 ? busy0 : busy1), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int base_rd, base_wr;
        for (int i = 0; i < 16; i++) begin
            mem0[i] = 8'h30 + 8'(i);
            mem1[i] = 8'h30 + 8'(i);
        end
        mem0[9] = 8'h08; mem0[10] = 8'h02; mem0[11] = 8'hE0; mem0[12] = 8'h0B;
        mem1[9] = 8'h08; mem1[10] = 8'h02; mem1[11] = 8'hE0; mem1[12] = 8'h0B;
        bus0.req_valid = 0; bus0.req_write = 0; bus0.req_addr = 0; bus0.req_len = 0;
        bus0.req_wdata = 0; bus0.rsp_ready = 1;
        bus1.req_valid = 0; bus1.req_write = 0; bus1.req_addr = 0; bus1.req_len = 0;
        bus1.req_wdata = 0; bus1.rsp_ready = 0;

        // Reset state
        repeat (2) tick();
        check("rst_req_ready", 32'(bus0.req_ready), 1);
        check("rst_busy", 32'(busy0), 0);
        check("rst_rsp_valid", 32'(bus0.rsp_valid), 0);
        check("rst_rsp_last", 32'(bus0.rsp_last), 0);
        check("rst_rsp_data", 32'(bus0.rsp_data), 0);
        check("rst_mem_read", 32'(bus0.mem_read), 0);
        check("rst_mem_write", 32'(bus0.mem_write), 0);
        check("rst_mem_address", 32'(bus0.mem_address), 0);
        check("rst_mem_data_in", 32'(bus0.mem_data_in), 0);
        check("rst_busy1", 32'(busy1), 0);
        rst_n = 1'b1;
        tick();

        // Single read of address 12
        base_rd = rd_cnt0;
        exp0.push_back({1'b1, 8'h0B});
        send(0, 1'b0, 4'd12, 4'd0, 8'h00);
        check("sr_c1_read", 32'(bus0.mem_read), 0);
        check("sr_c1_busy", 32'(busy0), 1);
        tick();
        check("sr_c2_read", 32'(bus0.mem_read), 1);
        check("sr_c2_addr", 32'(bus0.mem_address), 12);
        tick();
        check("sr_c3_read", 32'(bus0.mem_read), 0);
        check("sr_c3_valid", 32'(bus0.rsp_valid), 1);
        check("sr_c3_data", 32'(bus0.rsp_data), 32'h0B);
        check("sr_c3_last", 32'(bus0.rsp_last), 1);
        tick();
        check("sr_c4_ready", 32'(bus0.req_ready), 1);
        check("sr_read_cycles", 32'(rd_cnt0 - base_rd), 1);
        check("sr_sb_empty", 32'(exp0.size()), 0);

        // Four-beat burst from address 9
        stamp0.delete();
        exp0.push_back({1'b0, 8'h08});
        exp0.push_back({1'b0, 8'h02});
        exp0.push_back({1'b0, 8'hE0});
        exp0.push_back({1'b1, 8'h0B});
        send(0, 1'b0, 4'd9, 4'd3, 8'h00);
        wait_idle(0, 100);
        check("burst_sb_empty", 32'(exp0.size()), 0);
        check("burst_beats", 32'(stamp0.size()), 4);
        if (stamp0.size() == 4)
            for (int i = 1; i < 4; i++) check("burst_gap", 32'(stamp0[i] - stamp0[i-1]), 3);

        // Burst wrapping past the top of the address space
        raddr0.delete();
        exp0.push_back({1'b0, 8'h3E});
        exp0.push_back({1'b0, 8'h3F});
        exp0.push_back({1'b0, 8'h30});
        exp0.push_back({1'b1, 8'h31});
        send(0, 1'b0, 4'd14, 4'd3, 8'h00);
        wait_idle(0, 100);
        check("wrap_sb_empty", 32'(exp0.size()), 0);
        check("wrap_addr_count", 32'(raddr0.size()), 4);
        if (raddr0.size() == 4) begin
            check("wrap_addr0", 32'(raddr0[0]), 14);
            check("wrap_addr1", 32'(raddr0[1]), 15);
            check("wrap_addr2", 32'(raddr0[2]), 0);
            check("wrap_addr3", 32'(raddr0[3]), 1);
        end
        tick();

        // Write 0xA5 to address 13, then read it back
        base_wr = wr_cnt0;
        send(0, 1'b1, 4'd13, 4'd0, 8'hA5);
        check("wr_c1_addr", 32'(bus0.mem_address), 13);
        check("wr_c1_data", 32'(bus0.mem_data_in), 32'hA5);
        check("wr_c1_write", 32'(bus0.mem_write), 0);
        tick();
        check("wr_c2_write", 32'(bus0.mem_write), 1);
        check("wr_c2_read", 32'(bus0.mem_read), 0);
        check("wr_c2_addr", 32'(bus0.mem_address), 13);
        check("wr_c2_data", 32'(bus0.mem_data_in), 32'hA5);
        tick();
        check("wr_c3_write", 32'(bus0.mem_write), 0);
        check("wr_c3_busy", 32'(busy0), 1);
        check("wr_c3_addr", 32'(bus0.mem_address), 13);
        check("wr_c3_data", 32'(bus0.mem_data_in), 32'hA5);
        check("wr_c3_rsp_valid", 32'(bus0.rsp_valid), 0);
        tick();
        check("wr_c4_ready", 32'(bus0.req_ready), 1);
        check("wr_cycles", 32'(wr_cnt0 - base_wr), 1);
        check("wr_mem13", 32'(mem0[13]), 32'hA5);
        exp0.push_back({1'b1, 8'hA5});
        send(0, 1'b0, 4'd13, 4'd0, 8'h00);
        wait_idle(0, 100);
        check("rb_sb_empty", 32'(exp0.size()), 0);
        tick();

        // Two wait states with a five-cycle stall on the first beat
        base_rd = rd_cnt1;
        exp1.push_back({1'b0, 8'h08});
        exp1.push_back({1'b1, 8'h02});
        send(1, 1'b0, 4'd9, 4'd1, 8'h00);
        check("w2_c1_read", 32'(bus1.mem_read), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("w2_strobe", 32'(bus1.mem_read), 1);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            check("w2_stall_valid", 32'(bus1.rsp_valid), 1);
            check("w2_stall_data", 32'(bus1.rsp_data), 32'h08);
            check("w2_stall_last", 32'(bus1.rsp_last), 0);
            check("w2_stall_read", 32'(bus1.mem_read), 0);
            tick();
        end
        bus1.rsp_ready = 1'b1;
        wait_idle(1, 100);
        check("w2_sb_empty", 32'(exp1.size()), 0);
        check("w2_read_cycles", 32'(rd_cnt1 - base_rd), 6);

        // Request while busy, then reset during the second beat's strobe
        base_wr = wr_cnt0;
        exp0.push_back({1'b0, 8'h08});
        send(0, 1'b0, 4'd9, 4'd3, 8'h00);
        bus0.req_valid = 1'b1; bus0.req_write = 1'b1; bus0.req_addr = 4'd5;
        bus0.req_wdata = 8'h77;
        tick();
        check("bz_c2_read", 32'(bus0.mem_read), 1);
        check("bz_c2_ready", 32'(bus0.req_ready), 0);
        tick();
        bus0.req_valid = 1'b0;
        tick();
        tick();
        check("bz_c5_read", 32'(bus0.mem_read), 1);
        check("bz_c5_addr", 32'(bus0.mem_address), 10);
        rst_n = 1'b0;
        #1;
        check("ar_read", 32'(bus0.mem_read), 0);
        check("ar_rsp_valid", 32'(bus0.rsp_valid), 0);
        check("ar_busy", 32'(busy0), 0);
        tick();
        rst_n = 1'b1;
        base_rd = rd_cnt0;
        repeat (3) tick();
        check("ar_ready", 32'(bus0.req_ready), 1);
        check("ar_no_read", 32'(rd_cnt0 - base_rd), 0);
        check("ar_rsp_after", 32'(bus0.rsp_valid), 0);
        check("bz_no_write", 32'(wr_cnt0 - base_wr), 0);
        check("bz_mem5", 32'(mem0[5]), 32'h35);
        check("ar_sb_empty", 32'(exp0.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
